// File: rtl/seg_disp_pkg.sv
// Shared glyph codes and arbiter state encoding for the seven-segment display path.
// The glyph constants must stay in step with the scan driver's decoder.
package seg_disp_pkg;

    localparam logic [4:0] GLYPH_BLANK = 5'd19;
    localparam logic [4:0] GLYPH_LEFT  = 5'd21;
    localparam logic [4:0] GLYPH_RIGHT = 5'd22;
    localparam logic [4:0] GLYPH_HAPPY = 5'd23;
    localparam logic [4:0] GLYPH_SAD   = 5'd24;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        ALERT
    } state_e;

endpackage

// File: rtl/seg_rr_picker.sv
// Combinational round-robin search: first set request at or after start_i, wrapping.
module seg_rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         start_i,
    output logic               found_o,
    output logic [1:0]         idx_o
);

    logic [3:0] req_ext;

    // Pad to the full 2-bit index space so unused slots are simply never found.
    for (genvar gi = 0; gi < 4; gi++) begin : g_ext
        if (gi < NUM_REQ) begin : g_real
            assign req_ext[gi] = req_i[gi];
        end else begin : g_pad
            assign req_ext[gi] = 1'b0;
        end
    end

    always_comb begin
        found_o = 1'b0;
        idx_o   = start_i;
        for (int i = 3; i >= 0; i--) begin
            if (req_ext[start_i + 2'(i)]) begin
                found_o = 1'b1;
                idx_o   = start_i + 2'(i);
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Time-sliced round-robin owner of the 8-digit display, with a pre-emptive alert screen.
// All outputs are registered from the next-state values, so grant and digits change together.
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int HOLD_W      = 26
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [32*NUM_REQ-1:0]  i_data,
    input  logic                   i_lock,
    input  logic                   i_alert,
    input  logic                   i_alert_happy,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic [1:0]             o_owner,
    output logic                   o_switch,
    output logic [39:0]            o_disp_codes
);

    localparam logic [HOLD_W-1:0] CNT_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_e              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic [1:0]          rr_q, rr_d;
    logic [HOLD_W-1:0]   cnt_q, cnt_d;
    logic                happy_q, happy_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d, grant_last_q;
    logic                switch_q;
    logic [39:0]         codes_q, codes_d;

    logic                pick_found;
    logic [1:0]          pick_idx;
    logic                owner_req;
    logic [31:0]         data_arr [4];
    logic [31:0]         data_sel;
    logic [39:0]         codes_show, codes_alert;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    // rr_q always equals owner+1 while showing, so one picker serves both
    // fresh arbitration and "next requester after the owner".
    seg_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i   (i_req),
        .start_i (rr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign owner_req = |(i_req & onehot(owner_q));
    assign data_sel  = data_arr[owner_d];

    for (genvar gi = 0; gi < 4; gi++) begin : g_data
        if (gi < NUM_REQ) begin : g_real
            assign data_arr[gi] = i_data[32*gi +: 32];
        end else begin : g_pad
            assign data_arr[gi] = '0;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        assign codes_show[39-5*gi -: 5] = {1'b0, data_sel[31-4*gi -: 4]};
        if (gi == 0) begin : g_left
            assign codes_alert[39-5*gi -: 5] = GLYPH_LEFT;
        end else if (gi == 7) begin : g_right
            assign codes_alert[39-5*gi -: 5] = GLYPH_RIGHT;
        end else begin : g_face
            assign codes_alert[39-5*gi -: 5] = happy_d ? GLYPH_HAPPY : GLYPH_SAD;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q + 1'b1;
        happy_d = happy_q;
        if (i_alert) begin
            state_d = ALERT;
            cnt_d   = '0;
            happy_d = i_alert_happy;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (pick_found) begin
                        state_d = SHOW;
                        owner_d = pick_idx;
                    end
                end
                SHOW: begin
                    // A drop wins over slice expiry, and the lock never holds a dropped owner.
                    if (!owner_req) begin
                        cnt_d = '0;
                        if (pick_found) owner_d = pick_idx;
                        else            state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (!i_lock && pick_found) owner_d = pick_idx;
                    end
                end
                ALERT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (state_d == SHOW) begin
            rr_d = (int'(owner_d) == NUM_REQ - 1) ? 2'd0 : owner_d + 2'd1;
        end

        grant_d = (state_d == SHOW) ? onehot(owner_d) : '0;
        case (state_d)
            SHOW:    codes_d = codes_show;
            ALERT:   codes_d = codes_alert;
            default: codes_d = {8{GLYPH_BLANK}};
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            rr_q         <= '0;
            cnt_q        <= '0;
            happy_q      <= 1'b0;
            grant_q      <= '0;
            grant_last_q <= '0;
            switch_q     <= 1'b0;
            codes_q      <= {8{GLYPH_BLANK}};
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            happy_q      <= happy_d;
            grant_q      <= grant_d;
            grant_last_q <= grant_q;
            switch_q     <= (|grant_q) && (grant_q != grant_last_q);
            codes_q      <= codes_d;
        end
    end

    assign o_grant      = grant_q;
    assign o_owner      = owner_q;
    assign o_switch     = switch_q;
    assign o_disp_codes = codes_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with a 4-cycle slice; one line per comparison.
module tb_seg_display_arbiter;

    localparam logic [39:0] C_BLANK = {8{5'd19}};
    localparam logic [39:0] C_SAD   = {5'd21, {6{5'd24}}, 5'd22};
    localparam logic [39:0] C_HAPPY = {5'd21, {6{5'd23}}, 5'd22};
    localparam logic [39:0] C_D0    = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
    localparam logic [39:0] C_D1    = {5'd1, 5'd1, 5'd1, 5'd1, 5'd2, 5'd2, 5'd2, 5'd2};
    localparam logic [39:0] C_D2    = {5'd13, 5'd14, 5'd10, 5'd13, 5'd11, 5'd14, 5'd14, 5'd15};

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] data;
    logic         lock, alert, happy;
    logic [3:0]   grant;
    logic [1:0]   owner;
    logic         sw;
    logic [39:0]  codes;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    seg_display_arbiter #(
        .NUM_REQ     (4),
        .HOLD_CYCLES (4),
        .HOLD_W      (3)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_data        (data),
        .i_lock        (lock),
        .i_alert       (alert),
        .i_alert_happy (happy),
        .o_grant       (grant),
        .o_owner       (owner),
        .o_switch      (sw),
        .o_disp_codes  (codes)
    );

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (cyc %0d): got=%h exp=%h", tag, cyc, got, exp);
        end else begin
            $display("ok   %s (cyc %0d): %h", tag, cyc, got);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        logic [3:0]  exp_g;
        logic [39:0] exp_c;
        rst   = 1'b1;
        req   = 4'b1111;
        lock  = 1'b0;
        alert = 1'b0;
        happy = 1'b0;
        data  = {32'h0000_0000, 32'hDEAD_BEEF, 32'h1111_2222, 32'h1234_5678};

        tick(2);
        chk("rst_grant", grant, 0);
        chk("rst_codes", codes, C_BLANK);
        chk("rst_switch", sw, 0);
        chk("rst_owner", owner, 0);

        rst = 1'b0;
        cyc = 0;
        tick();  // cycle 1
        chk("first_grant", grant, 4'b0001);
        chk("first_codes", codes, C_D0);

        // Rotation between requesters 0 and 2, four cycles each.
        req = 4'b0101;
        for (int k = 2; k <= 12; k++) begin
            tick();
            exp_g = (((k - 1) / 4) % 2 == 1) ? 4'b0100 : 4'b0001;
            exp_c = (exp_g == 4'b0100) ? C_D2 : C_D0;
            chk("rot_grant", grant, exp_g);
            chk("rot_codes", codes, exp_c);
            chk("rot_switch", sw, (k == 2 || k == 6 || k == 10) ? 1 : 0);
        end

        tick(5);  // cycle 17
        chk("rot_back0", grant, 4'b0001);
        tick();   // cycle 18, owner 0 mid-slice
        req = 4'b0100;
        tick();   // cycle 19
        chk("drop_grant", grant, 4'b0100);
        chk("drop_codes", codes, C_D2);
        req = 4'b0101;
        tick(3);  // cycle 22: fresh slice keeps owner 2
        chk("drop_restart", grant, 4'b0100);
        tick();   // cycle 23
        chk("drop_expire", grant, 4'b0001);
        tick();   // cycle 24
        req = 4'b0000;
        tick();   // cycle 25
        chk("idle_grant", grant, 0);
        chk("idle_codes", codes, C_BLANK);
        chk("idle_owner", owner, 0);

        req = 4'b0011;
        tick();   // cycle 26: rr pointer is 1
        chk("lock_grant", grant, 4'b0010);
        chk("lock_codes", codes, C_D1);
        lock = 1'b1;
        for (int k = 27; k <= 41; k++) begin
            tick();
            chk("lock_hold", grant, 4'b0010);
            if (k == 31 || k == 35) chk("lock_noswitch", sw, 0);
            if (k == 38) lock = 1'b0;
        end
        tick();   // cycle 42
        chk("unlock_switch", grant, 4'b0001);

        tick();   // cycle 43
        alert = 1'b1;
        happy = 1'b0;
        tick();   // cycle 44
        alert = 1'b0;
        chk("alert_grant", grant, 0);
        chk("alert_sad", codes, C_SAD);
        tick(3);  // cycle 47
        chk("alert_sad_end", codes, C_SAD);
        tick();   // cycle 48
        chk("alert_idle_grant", grant, 0);
        chk("alert_idle_codes", codes, C_BLANK);
        tick();   // cycle 49
        chk("alert_regrant", grant, 4'b0010);

        alert = 1'b1;
        happy = 1'b0;
        tick();   // cycle 50
        alert = 1'b0;
        happy = 1'b1;
        chk("alert2_sad", codes, C_SAD);
        tick();   // cycle 51: flag only sampled with the pulse
        chk("alert2_hold_flag", codes, C_SAD);
        alert = 1'b1;
        tick();   // cycle 52
        alert = 1'b0;
        happy = 1'b0;
        chk("alert2_happy", codes, C_HAPPY);
        chk("alert2_grant", grant, 0);
        tick(3);  // cycle 55
        chk("alert2_happy_end", codes, C_HAPPY);
        tick();   // cycle 56
        chk("alert2_idle", codes, C_BLANK);
        tick();   // cycle 57: rr pointer 2 wraps to requester 0
        chk("alert2_regrant", grant, 4'b0001);

        tick(3);  // cycle 60: owner 0 at slice end
        req   = 4'b0010;
        alert = 1'b1;
        happy = 1'b1;
        tick();   // cycle 61
        alert = 1'b0;
        req   = 4'b0011;
        chk("coll_grant", grant, 0);
        chk("coll_codes", codes, C_HAPPY);
        chk("coll_owner", owner, 0);
        tick(4);  // cycle 65
        chk("coll_idle", grant, 0);
        tick();   // cycle 66
        chk("coll_rr_grant", grant, 4'b0010);
        chk("coll_rr_owner", owner, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
